comp_row_table: RTL and testbench
=================================

# comp_row_table

Parametrised compensation-row table that captures, per weight column, the row indices needing compensation as the weight loader streams them. It replaces the fixed 24-entry, modulo-indexed recorder with an explicit column/slot pointer, overflow detection and a registered per-column read port. It sits beside the activation memory: the loader fills it; after `done` the array controller reads one column's compensation set per request.

## Interface
- `NUM_COLS`, 8, number of weight columns tracked
- `SLOTS_PER_COL`, 3, compensation entries per column
- `ROW_W`, 3, width of a row index; stored entry is `ROW_W+1` bits, MSB = invalid flag
- `clk` input 1, single clock, rising edge
- `rst` input 1, synchronous, active-high reset
- `comp_valid` input 1, `comp_row` is valid this cycle
- `comp_row` input `ROW_W`, compensation row index for the current column
- `change_col` input 1, loader finished current column; advance to next
- `done` input 1, loading complete; enter READY
- `start` input 1, clear table and begin a new load
- `rd_en` input 1, read request (honoured in READY only)
- `rd_col` input `$clog2(NUM_COLS)`, column to read
- `rd_rows` output `SLOTS_PER_COL*(ROW_W+1)`, slot k at bits [k*(ROW_W+1) +: ROW_W+1]
- `rd_mask` output `SLOTS_PER_COL`, bit k = slot k holds a valid row
- `rd_valid` output 1, `rd_rows`/`rd_mask` valid
- `ready` output 1, table is in READY
- `overflow` output 1, sticky: a compensation was dropped
- `col_idx` output `$clog2(NUM_COLS+1)`, current load column pointer

## Operation
- INVALID entry = {1'b1, ROW_W'b0} (8 for ROW_W=3).
- States: LOAD, READY. Reset → LOAD, every entry INVALID, col=0, slot=0, overflow=0.
- LOAD, `comp_valid`: if col<NUM_COLS and slot<SLOTS_PER_COL, write {1'b0,comp_row} to [col][slot], slot++; else drop and set overflow.
- LOAD, `change_col`: col++ (saturates at NUM_COLS, meaning full), slot=0. Unfilled slots of the left column stay INVALID.
- `comp_valid` and `change_col` together: write to the current column first, then advance.
- `done` in LOAD → READY, col=0, slot=0, and table retained. `done` has priority over `comp_valid` and `change_col` in the same cycle; those are ignored.
- READY: `comp_valid`, `change_col` and `done` are ignored.
- `start`, in either state: all entries INVALID, overflow=0, col=slot=0, → LOAD. `start` beats every other input.
- Read: `rd_en` in READY. The next cycle gives rd_valid=1, rd_rows=column `rd_col`, rd_mask from the entry MSBs. If rd_col≥NUM_COLS: rd_valid=1, all slots INVALID, mask=0.
- `rd_en` outside READY: no response; rd_valid=0 and rd_rows/rd_mask hold.

## Timing
- Reset values: rd_valid=0, rd_rows all INVALID, rd_mask=0, ready=0, overflow=0, col_idx=0.
- Writes take effect at the next edge. A read issued the cycle after a write returns the written value.
- Read latency is 1 cycle, fully pipelined: back-to-back `rd_en` gives back-to-back `rd_valid`.
- `ready` is registered and rises the cycle after `done` is sampled. It falls the cycle after `start`.
- A `start` with `rd_en` in the same cycle: the read is dropped and rd_valid=0 next cycle.
- Reset mid-load or mid-read: identical to power-on reset.

## Structure
- `comp_row_pkg` holds: the state enum {LOAD, READY}, the `comp_entry_t` width helper, and the INVALID constant function of ROW_W.
- Sub-module `comp_row_rd_port`: registered column select, mask derivation and out-of-range handling. The pointer and table logic stay in the top module.
- Index uses separate col/slot counters, with no modulo arithmetic.

## Test plan
- Defaults; comp rows 5,2 then change_col; then 7 then change_col; then done; read col0 and col1 → col0 {5,2,INV} mask 3'b011; col1 {7,INV,INV} mask 3'b001.
- Four comp_valid in col0 without change_col → first three stored, fourth dropped, overflow=1 and stays 1 through done until start.
- comp_valid(row 4) with change_col in the same cycle at col2 → [2][0]=4, col_idx=3, slot=0.
- Nine change_col pulses → col_idx saturates at 8. Later comp_valid → dropped, overflow=1.
- READY, rd_en with rd_col=9 (NUM_COLS=16 build) reading an empty column → mask 0. Then start → ready=0 next cycle and subsequent reads produce no rd_valid.
- rst asserted mid-load after three writes → all entries INVALID, col_idx=0, outputs at reset values on the next cycle.

Source files
------------

// File: rtl/comp_row_pkg.sv
// Shared types and constants for the compensation-row table and its read port.
package comp_row_pkg;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int unsigned DEF_ROW_W = 3;

    // Stored entry: MSB is the invalid flag, low ROW_W bits the row index.
    typedef logic [DEF_ROW_W:0] comp_entry_t;

    function automatic int unsigned comp_entry_w(input int unsigned row_w);
        return row_w + 1;
    endfunction

    function automatic logic [31:0] comp_invalid(input int unsigned row_w);
        return 32'(1) << row_w;
    endfunction

endpackage

// File: rtl/comp_row_table_rd.sv
// Registered per-column read port: column select, mask derivation, out-of-range fill.
module comp_row_rd_port
    import comp_row_pkg::*;
#(
    parameter int unsigned NUM_COLS      = 8,
    parameter int unsigned SLOTS_PER_COL = 3,
    parameter int unsigned ROW_W         = 3
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            rd_req,
    input  logic [$clog2(NUM_COLS)-1:0]                     rd_col,
    input  logic [NUM_COLS*SLOTS_PER_COL*(ROW_W+1)-1:0]     table_flat,
    output logic [SLOTS_PER_COL*(ROW_W+1)-1:0]              rd_rows,
    output logic [SLOTS_PER_COL-1:0]                        rd_mask,
    output logic                                            rd_valid
);

    localparam int unsigned EW = comp_entry_w(ROW_W);
    localparam int unsigned RW = SLOTS_PER_COL * EW;
    localparam logic [EW-1:0] INVALID = EW'(comp_invalid(ROW_W));

    logic [RW-1:0]            rows_d, rows_q;
    logic [SLOTS_PER_COL-1:0] mask_d, mask_q;
    logic                     valid_d, valid_q;

    always_comb begin
        rows_d  = rows_q;
        mask_d  = mask_q;
        valid_d = 1'b0;
        if (rd_req) begin
            valid_d = 1'b1;
            for (int unsigned k = 0; k < SLOTS_PER_COL; k++) begin
                rows_d[k*EW +: EW] = INVALID;
            end
            // An out-of-range column matches no iteration and keeps the INVALID fill.
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                if (32'(rd_col) == c) begin
                    rows_d = table_flat[c*RW +: RW];
                end
            end
            for (int unsigned k = 0; k < SLOTS_PER_COL; k++) begin
                mask_d[k] = ~rows_d[k*EW + EW - 1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q  <= {SLOTS_PER_COL{INVALID}};
            mask_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rows_q  <= rows_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
        end
    end

    assign rd_rows  = rows_q;
    assign rd_mask  = mask_q;
    assign rd_valid = valid_q;

endmodule

// File: rtl/comp_row_table.sv
// Compensation-row table: captures per-column row indices from the weight loader,
// then serves one column per read request once loading is done.
module comp_row_table
    import comp_row_pkg::*;
#(
    parameter int unsigned NUM_COLS      = 8,
    parameter int unsigned SLOTS_PER_COL = 3,
    parameter int unsigned ROW_W         = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                comp_valid,
    input  logic [ROW_W-1:0]                    comp_row,
    input  logic                                change_col,
    input  logic                                done,
    input  logic                                start,
    input  logic                                rd_en,
    input  logic [$clog2(NUM_COLS)-1:0]         rd_col,
    output logic [SLOTS_PER_COL*(ROW_W+1)-1:0]  rd_rows,
    output logic [SLOTS_PER_COL-1:0]            rd_mask,
    output logic                                rd_valid,
    output logic                                ready,
    output logic                                overflow,
    output logic [$clog2(NUM_COLS+1)-1:0]       col_idx
);

    localparam int unsigned EW = comp_entry_w(ROW_W);
    localparam int unsigned CW = $clog2(NUM_COLS + 1);
    localparam int unsigned SW = $clog2(SLOTS_PER_COL + 1);
    localparam logic [EW-1:0] INVALID = EW'(comp_invalid(ROW_W));

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          ovf_q, ovf_d;
    logic [EW-1:0] table_q [NUM_COLS][SLOTS_PER_COL];
    logic [EW-1:0] table_d [NUM_COLS][SLOTS_PER_COL];

    logic [NUM_COLS*SLOTS_PER_COL*EW-1:0] table_flat;
    logic                                 rd_req;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        slot_d  = slot_q;
        ovf_d   = ovf_q;
        table_d = table_q;
        if (start) begin
            state_d = ST_LOAD;
            col_d   = '0;
            slot_d  = '0;
            ovf_d   = 1'b0;
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                for (int unsigned s = 0; s < SLOTS_PER_COL; s++) begin
                    table_d[c][s] = INVALID;
                end
            end
        end else if (state_q == ST_LOAD) begin
            if (done) begin
                state_d = ST_READY;
                col_d   = '0;
                slot_d  = '0;
            end else begin
                if (comp_valid) begin
                    if (32'(col_q) < NUM_COLS && 32'(slot_q) < SLOTS_PER_COL) begin
                        for (int unsigned c = 0; c < NUM_COLS; c++) begin
                            for (int unsigned s = 0; s < SLOTS_PER_COL; s++) begin
                                if (32'(col_q) == c && 32'(slot_q) == s) begin
                                    table_d[c][s] = {1'b0, comp_row};
                                end
                            end
                        end
                        slot_d = slot_q + SW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // Column advance follows the write so a coincident entry lands in the old column.
                if (change_col) begin
                    if (32'(col_q) < NUM_COLS) begin
                        col_d = col_q + CW'(1);
                    end
                    slot_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            col_q   <= '0;
            slot_q  <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                for (int unsigned s = 0; s < SLOTS_PER_COL; s++) begin
                    table_q[c][s] <= INVALID;
                end
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            slot_q  <= slot_d;
            ovf_q   <= ovf_d;
            table_q <= table_d;
        end
    end

    always_comb begin
        table_flat = '0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            for (int unsigned s = 0; s < SLOTS_PER_COL; s++) begin
                table_flat[(c*SLOTS_PER_COL + s)*EW +: EW] = table_q[c][s];
            end
        end
    end

    assign rd_req = rd_en && (state_q == ST_READY) && !start;

    comp_row_rd_port #(
        .NUM_COLS      (NUM_COLS),
        .SLOTS_PER_COL (SLOTS_PER_COL),
        .ROW_W         (ROW_W)
    ) u_rd_port (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_col     (rd_col),
        .table_flat (table_flat),
        .rd_rows    (rd_rows),
        .rd_mask    (rd_mask),
        .rd_valid   (rd_valid)
    );

    assign ready    = (state_q == ST_READY);
    assign overflow = ovf_q;
    assign col_idx  = col_q;

endmodule

// File: tb/tb_comp_row_table.sv
// Bench for comp_row_table: behavioural table model feeding a read scoreboard.
module tb_comp_row_table;

    logic        clk = 1'b0;
    logic        rst, comp_valid, change_col, done, start, rd_en;
    logic [2:0]  comp_row;
    logic [3:0]  rd_col16;

    logic [11:0] rd_rows,  rd_rows16;
    logic [2:0]  rd_mask,  rd_mask16;
    logic        rd_valid, rd_valid16, ready, ready16, overflow, overflow16;
    logic [3:0]  col_idx;
    logic [4:0]  col_idx16;

    always #5 clk = ~clk;

    comp_row_table #(.NUM_COLS(8), .SLOTS_PER_COL(3), .ROW_W(3)) u_dut (
        .clk(clk), .rst(rst), .comp_valid(comp_valid), .comp_row(comp_row),
        .change_col(change_col), .done(done), .start(start), .rd_en(rd_en),
        .rd_col(rd_col16[2:0]), .rd_rows(rd_rows), .rd_mask(rd_mask),
        .rd_valid(rd_valid), .ready(ready), .overflow(overflow), .col_idx(col_idx)
    );

    comp_row_table #(.NUM_COLS(16), .SLOTS_PER_COL(3), .ROW_W(3)) u_dut16 (
        .clk(clk), .rst(rst), .comp_valid(comp_valid), .comp_row(comp_row),
        .change_col(change_col), .done(done), .start(start), .rd_en(rd_en),
        .rd_col(rd_col16), .rd_rows(rd_rows16), .rd_mask(rd_mask16),
        .rd_valid(rd_valid16), .ready(ready16), .overflow(overflow16), .col_idx(col_idx16)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [11:0] rows;
        logic [2:0]  mask;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    // Reference model of the 8-column build; 8 marks an empty slot.
    int m_tab [8][3];
    int m_col, m_slot;
    bit m_ovf, m_ready;
    bit mon_en = 1'b0;

    task automatic model_clear();
        for (int c = 0; c < 8; c++)
            for (int s = 0; s < 3; s++) m_tab[c][s] = 8;
        m_col = 0; m_slot = 0; m_ovf = 1'b0; m_ready = 1'b0;
    endtask

    function automatic rd_exp_t model_read(input int c);
        rd_exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.rows[k*4 +: 4] = 4'(m_tab[c][k]);
            e.mask[k]        = (m_tab[c][k] != 8);
        end
        return e;
    endfunction

    task automatic model_edge();
        if (rst) begin
            exp_q.delete();
            model_clear();
        end else begin
            if (rd_en && m_ready && !start) exp_q.push_back(model_read(int'(rd_col16[2:0])));
            if (start) begin
                model_clear();
            end else if (!m_ready) begin
                if (done) begin
                    m_ready = 1'b1; m_col = 0; m_slot = 0;
                end else begin
                    if (comp_valid) begin
                        if (m_col < 8 && m_slot < 3) begin
                            m_tab[m_col][m_slot] = int'(comp_row);
                            m_slot++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    if (change_col) begin
                        if (m_col < 8) m_col++;
                        m_slot = 0;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic cv, input logic [2:0] row, input logic cc, input logic dn,
                       input logic st, input logic re, input logic [3:0] rc, input logic rs);
        rst = rs; comp_valid = cv; comp_row = row; change_col = cc; done = dn;
        start = st; rd_en = re; rd_col16 = rc;
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0; comp_valid = 1'b0; comp_row = '0; change_col = 1'b0; done = 1'b0;
        start = 1'b0; rd_en = 1'b0; rd_col16 = '0;
    endtask

    task automatic idle();                      cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic comp(input logic [2:0] r);   cyc(1, r, 0, 0, 0, 0, 0, 0); endtask
    task automatic comp_cc(input logic [2:0] r); cyc(1, r, 1, 0, 0, 0, 0, 0); endtask
    task automatic chg();                       cyc(0, 0, 1, 0, 0, 0, 0, 0); endtask
    task automatic fin();                       cyc(0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic strt();                      cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
    task automatic rd(input logic [3:0] c);     cyc(0, 0, 0, 0, 0, 1, c, 0); endtask
    task automatic rst_cyc();                   cyc(0, 0, 0, 0, 0, 0, 0, 1); endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_ready"},    ready,    m_ready);
        check_eq({tag, "_overflow"}, overflow, m_ovf);
        check_eq({tag, "_col_idx"},  col_idx,  m_col);
    endtask

    always @(negedge clk) begin
        rd_exp_t e;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("sb_rd_valid", rd_valid, 1);
                check_eq("sb_rd_rows",  rd_rows,  e.rows);
                check_eq("sb_rd_mask",  rd_mask,  e.mask);
            end else begin
                check_eq("sb_rd_idle", rd_valid, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; comp_valid = 1'b0; comp_row = '0; change_col = 1'b0; done = 1'b0;
        start = 1'b0; rd_en = 1'b0; rd_col16 = '0;
        model_clear();
        rst_cyc(); rst_cyc();
        check_eq("rst_ready", ready, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_col_idx", col_idx, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_rows", rd_rows, 12'h888);
        check_eq("rst_rd_mask", rd_mask, 0);
        mon_en = 1'b1;

        // Basic fill and read-back
        comp(5); comp(2); chg(); comp(7); chg();
        check_eq("t1_col_idx", col_idx, 2);
        fin();
        check_eq("t1_ready", ready, 1);
        check_eq("t1_col_idx_rdy", col_idx, 0);
        rd(0);
        check_eq("t1_col0_rows", rd_rows, 12'h825);
        check_eq("t1_col0_mask", rd_mask, 3'b011);
        rd(1);
        check_eq("t1_col1_rows", rd_rows, 12'h887);
        check_eq("t1_col1_mask", rd_mask, 3'b001);
        idle();
        check_state("t1");

        // Slot overflow, sticky through done
        strt();
        check_eq("t2_ready_fall", ready, 0);
        comp(1); comp(2); comp(3);
        check_eq("t2_ovf_pre", overflow, 0);
        comp(4);
        check_eq("t2_ovf_set", overflow, 1);
        fin();
        check_eq("t2_ovf_done", overflow, 1);
        rd(0);
        check_eq("t2_col0_rows", rd_rows, 12'h321);
        check_eq("t2_col0_mask", rd_mask, 3'b111);
        idle();
        check_state("t2");
        strt();
        check_eq("t2_ovf_clr", overflow, 0);

        // Write and column advance in the same cycle
        chg(); chg();
        comp_cc(4);
        check_eq("t3_col_idx", col_idx, 3);
        comp(6);
        fin();
        rd(2);
        check_eq("t3_col2_rows", rd_rows, 12'h884);
        check_eq("t3_col2_mask", rd_mask, 3'b001);
        rd(3);
        check_eq("t3_col3_rows", rd_rows, 12'h886);
        idle();

        // Column pointer saturation
        strt();
        repeat (9) chg();
        check_eq("t4_col_sat", col_idx, 8);
        check_eq("t4_col16", col_idx16, 9);
        check_eq("t4_ovf_pre", overflow, 0);
        comp(1);
        check_eq("t4_ovf_full", overflow, 1);
        fin();
        rd(7);
        check_eq("t4_col7_mask", rd_mask, 0);
        idle();
        check_state("t4");

        // Wide build read, then start with a coincident read
        strt();
        comp(3);
        fin();
        rd(9);
        check_eq("t5_w16_valid", rd_valid16, 1);
        check_eq("t5_w16_rows", rd_rows16, 12'h888);
        check_eq("t5_w16_mask", rd_mask16, 0);
        rd(0);
        check_eq("t5_col0_rows", rd_rows, 12'h883);
        cyc(0, 0, 0, 0, 1, 1, 4'd0, 0);
        check_eq("t5_start_ready", ready, 0);
        check_eq("t5_start_drop", rd_valid, 0);
        check_eq("t5_rows_hold", rd_rows, 12'h883);
        rd(0); rd(0);
        check_eq("t5_load_noread", rd_valid, 0);
        check_eq("t5_load_hold", rd_mask, 3'b001);

        // Reset in the middle of a load
        strt();
        comp(1); comp(2); comp(3);
        rst_cyc();
        check_eq("t6_col_idx", col_idx, 0);
        check_eq("t6_ready", ready, 0);
        check_eq("t6_overflow", overflow, 0);
        check_eq("t6_rd_valid", rd_valid, 0);
        check_eq("t6_rd_rows", rd_rows, 12'h888);
        check_eq("t6_rd_mask", rd_mask, 0);
        fin();
        rd(0);
        check_eq("t6_col0_rows", rd_rows, 12'h888);
        check_eq("t6_col0_mask", rd_mask, 0);
        idle(); idle();
        check_eq("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
